// File: rtl/instr_fetcher_if.sv
// Fetch-stage bundle: instruction-queue request/response plus byte-wide memory port.
// master = fetcher side, slave = queue/controller side.
interface instr_fetcher_if;
    logic        is_exception_from_rob;
    logic [31:0] pc_from_iq;
    logic        is_empty_from_iq;
    logic        is_stall_to_iq;
    logic        is_finish_to_iq;
    logic [31:0] instr_to_iq;
    logic        is_mem_req_to_mc;
    logic        is_mem_grant_from_mc;
    logic [31:0] mem_addr_to_mc;
    logic [7:0]  mem_byte_from_mc;

    modport master (
        input  is_exception_from_rob, pc_from_iq, is_empty_from_iq,
        input  is_mem_grant_from_mc, mem_byte_from_mc,
        output is_stall_to_iq, is_finish_to_iq, instr_to_iq,
        output is_mem_req_to_mc, mem_addr_to_mc
    );

    modport slave (
        output is_exception_from_rob, pc_from_iq, is_empty_from_iq,
        output is_mem_grant_from_mc, mem_byte_from_mc,
        input  is_stall_to_iq, is_finish_to_iq, instr_to_iq,
        input  is_mem_req_to_mc, mem_addr_to_mc
    );
endinterface

// File: rtl/instr_fetcher.sv
// Instruction fetch with a direct-mapped one-word-per-entry icache.
// Latency: hit finishes 1 cycle after accept; miss finishes 5 cycles after the first grant.
// Backpressure: stall while a miss is in flight and for the finish cycle of a hit.
module instr_fetcher #(
    parameter int IndexBits = 5
) (
    input  logic            clk,
    input  logic            rst,
    instr_fetcher_if.master bus
);
    localparam int Entries = 1 << IndexBits;
    localparam int TagBits = 30 - IndexBits;

    typedef enum logic [1:0] {IDLE, WAIT, READ} state_t;

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [29:0]          word_pc_q, word_pc_d;
    logic [23:0]          buf_q, buf_d;
    logic [Entries-1:0]   valid_q, valid_d;
    logic                 stall_q, stall_d;
    logic                 finish_q, finish_d;
    logic [31:0]          instr_q, instr_d;
    logic                 req_q, req_d;
    logic [31:0]          addr_q, addr_d;

    logic [TagBits-1:0]   tag_mem  [Entries];
    logic [31:0]          data_mem [Entries];

    logic [IndexBits-1:0] req_idx, cur_idx;
    logic [TagBits-1:0]   req_tag, cur_tag;
    logic                 hit, accept, hit_acc, fill_en;
    logic [31:0]          fill_data;

    assign req_idx   = bus.pc_from_iq[IndexBits+1:2];
    assign req_tag   = bus.pc_from_iq[31:IndexBits+2];
    assign cur_idx   = word_pc_q[IndexBits-1:0];
    assign cur_tag   = word_pc_q[29:IndexBits];
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign accept    = !stall_q && !bus.is_empty_from_iq && !bus.is_exception_from_rob;
    assign fill_data = {bus.mem_byte_from_mc, buf_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_pc_d = word_pc_q;
        buf_d     = buf_q;
        valid_d   = valid_q;
        finish_d  = 1'b0;
        instr_d   = instr_q;
        req_d     = req_q;
        addr_d    = addr_q;
        hit_acc   = 1'b0;
        fill_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        hit_acc  = 1'b1;
                        finish_d = 1'b1;
                        instr_d  = data_mem[req_idx];
                    end else begin
                        state_d   = WAIT;
                        req_d     = 1'b1;
                        word_pc_d = bus.pc_from_iq[31:2];
                        addr_d    = {bus.pc_from_iq[31:2], 2'b00};
                    end
                end
            end
            WAIT: begin
                // The granted WAIT cycle already carries byte +0.
                if (bus.is_mem_grant_from_mc) begin
                    state_d = READ;
                    cnt_d   = 2'd0;
                    addr_d  = {addr_q[31:2], 2'b01};
                end
            end
            READ: begin
                if (cnt_q == 2'd3) begin
                    fill_en          = 1'b1;
                    valid_d[cur_idx] = 1'b1;
                    finish_d         = 1'b1;
                    instr_d          = fill_data;
                    state_d          = IDLE;
                    cnt_d            = 2'd0;
                end else begin
                    case (cnt_q)
                        2'd0:    buf_d[7:0]   = bus.mem_byte_from_mc;
                        2'd1:    buf_d[15:8]  = bus.mem_byte_from_mc;
                        default: buf_d[23:16] = bus.mem_byte_from_mc;
                    endcase
                    cnt_d  = cnt_q + 2'd1;
                    req_d  = (cnt_q < 2'd2);
                    addr_d = {addr_q[31:2], addr_q[1:0] + 2'd1};
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d != IDLE) || hit_acc;

        // A flush drops any partial word; cache contents stay valid.
        if (bus.is_exception_from_rob) begin
            state_d  = IDLE;
            req_d    = 1'b0;
            cnt_d    = 2'd0;
            finish_d = 1'b0;
            stall_d  = 1'b0;
            instr_d  = instr_q;
            valid_d  = valid_q;
            fill_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            word_pc_q <= '0;
            buf_q     <= '0;
            valid_q   <= '0;
            stall_q   <= 1'b0;
            finish_q  <= 1'b0;
            instr_q   <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_pc_q <= word_pc_d;
            buf_q     <= buf_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
            finish_q  <= finish_d;
            instr_q   <= instr_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en && !rst) begin
            tag_mem[cur_idx]  <= cur_tag;
            data_mem[cur_idx] <= fill_data;
        end
    end

    assign bus.is_stall_to_iq   = stall_q;
    assign bus.is_finish_to_iq  = finish_q;
    assign bus.instr_to_iq      = instr_q;
    assign bus.is_mem_req_to_mc = req_q;
    assign bus.mem_addr_to_mc   = addr_q;
endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher: misses, hits, conflicts, delayed grant, flush, reset.
module tb_instr_fetcher;
    logic clk;
    logic rst;
    logic grant_en;
    int   total;
    int   bad;

    instr_fetcher_if bus();

    instr_fetcher #(.IndexBits(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.is_mem_grant_from_mc = grant_en && bus.is_mem_req_to_mc;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        case (a[31:2])
            30'h400: w = 32'h00100513;   // 0x1000
            30'h420: w = 32'hDEADBEEF;   // 0x1080
            30'h800: w = 32'h12345678;   // 0x2000
            default: w = {a[7:2], 2'b11, a[7:2], 2'b10, a[7:2], 2'b01, a[7:2], 2'b00} ^ 32'hA5A5A5A5;
        endcase
        return w[a[1:0]*8 +: 8];
    endfunction

    always @(posedge clk)
        if (bus.is_mem_grant_from_mc) bus.mem_byte_from_mc <= byte_at(bus.mem_addr_to_mc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request for one edge; on return we are in cycle t+1.
    task automatic issue(input logic [31:0] pc);
        bus.pc_from_iq       = pc;
        bus.is_empty_from_iq = 1'b0;
        tick();
        bus.is_empty_from_iq = 1'b1;
    endtask

    // Miss with grant always available: req t+1..t+4, finish at t+6.
    task automatic do_miss(input logic [31:0] pc, input logic [31:0] word);
        logic [31:0] base;
        base = {pc[31:2], 2'b00};
        issue(pc);
        for (int k = 0; k < 4; k++) begin
            check("miss_req", {31'd0, bus.is_mem_req_to_mc}, 32'd1);
            check("miss_addr", bus.mem_addr_to_mc, base + k);
            check("miss_stall", {31'd0, bus.is_stall_to_iq}, 32'd1);
            check("miss_nofin", {31'd0, bus.is_finish_to_iq}, 32'd0);
            tick();
        end
        check("miss_req_drop", {31'd0, bus.is_mem_req_to_mc}, 32'd0);
        check("miss_nofin5", {31'd0, bus.is_finish_to_iq}, 32'd0);
        tick();
        check("miss_fin", {31'd0, bus.is_finish_to_iq}, 32'd1);
        check("miss_instr", bus.instr_to_iq, word);
        check("miss_stall_end", {31'd0, bus.is_stall_to_iq}, 32'd0);
    endtask

    task automatic do_hit(input logic [31:0] pc, input logic [31:0] word);
        issue(pc);
        check("hit_fin", {31'd0, bus.is_finish_to_iq}, 32'd1);
        check("hit_instr", bus.instr_to_iq, word);
        check("hit_stall", {31'd0, bus.is_stall_to_iq}, 32'd1);
        check("hit_noreq", {31'd0, bus.is_mem_req_to_mc}, 32'd0);
        tick();
        check("hit_fin_drop", {31'd0, bus.is_finish_to_iq}, 32'd0);
        check("hit_stall_drop", {31'd0, bus.is_stall_to_iq}, 32'd0);
        check("hit_instr_hold", bus.instr_to_iq, word);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        grant_en                  = 1'b1;
        bus.is_exception_from_rob = 1'b0;
        bus.pc_from_iq            = 32'h0;
        bus.is_empty_from_iq      = 1'b1;
        bus.mem_byte_from_mc      = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_stall", {31'd0, bus.is_stall_to_iq}, 32'd0);
        check("rst_fin", {31'd0, bus.is_finish_to_iq}, 32'd0);
        check("rst_instr", bus.instr_to_iq, 32'd0);
        check("rst_req", {31'd0, bus.is_mem_req_to_mc}, 32'd0);
        check("rst_addr", bus.mem_addr_to_mc, 32'd0);

        // Cold fill then hit.
        do_miss(32'h1000, 32'h00100513);
        do_hit(32'h1000, 32'h00100513);

        // Same-index conflict evicts, and the original then misses again.
        do_miss(32'h1080, 32'hDEADBEEF);
        do_hit(32'h1080, 32'hDEADBEEF);
        do_miss(32'h1000, 32'h00100513);

        // Grant withheld for three cycles.
        grant_en = 1'b0;
        issue(32'h3000);
        for (int k = 0; k < 3; k++) begin
            check("dly_req", {31'd0, bus.is_mem_req_to_mc}, 32'd1);
            check("dly_stall", {31'd0, bus.is_stall_to_iq}, 32'd1);
            tick();
        end
        grant_en = 1'b1;
        check("dly_addr0", bus.mem_addr_to_mc, 32'h3000);
        for (int k = 1; k < 5; k++) begin
            tick();
            check("dly_stall_rd", {31'd0, bus.is_stall_to_iq}, 32'd1);
            check("dly_nofin", {31'd0, bus.is_finish_to_iq}, 32'd0);
        end
        tick();
        check("dly_fin", {31'd0, bus.is_finish_to_iq}, 32'd1);
        check("dly_instr", bus.instr_to_iq, 32'hA6A7A4A5);

        // Flush during the second READ cycle.
        issue(32'h2000);
        tick();
        tick();
        bus.is_exception_from_rob = 1'b1;
        tick();
        bus.is_exception_from_rob = 1'b0;
        check("exc_req", {31'd0, bus.is_mem_req_to_mc}, 32'd0);
        check("exc_stall", {31'd0, bus.is_stall_to_iq}, 32'd0);
        check("exc_fin", {31'd0, bus.is_finish_to_iq}, 32'd0);
        check("exc_instr_hold", bus.instr_to_iq, 32'hA6A7A4A5);
        do_miss(32'h2000, 32'h12345678);

        // Queue full: no accept even with a valid-looking PC.
        bus.pc_from_iq = 32'h1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("empty_req", {31'd0, bus.is_mem_req_to_mc}, 32'd0);
            check("empty_fin", {31'd0, bus.is_finish_to_iq}, 32'd0);
            check("empty_stall", {31'd0, bus.is_stall_to_iq}, 32'd0);
            check("empty_instr", bus.instr_to_iq, 32'h12345678);
        end

        // Reset mid-miss invalidates the cache.
        issue(32'h1080);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_req", {31'd0, bus.is_mem_req_to_mc}, 32'd0);
        check("mrst_stall", {31'd0, bus.is_stall_to_iq}, 32'd0);
        check("mrst_fin", {31'd0, bus.is_finish_to_iq}, 32'd0);
        check("mrst_instr", bus.instr_to_iq, 32'd0);
        do_miss(32'h1000, 32'h00100513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
